mem_rd_streamer: RTL and testbench
==================================

Name: mem_rd_streamer

Overview:
Burst read engine that sits directly downstream of the on-chip memory block. It issues rd_en/rd_addr to the memory's read port and turns the 1-cycle-latency read data into an AXI4-Stream master burst with tvalid/tready/tlast. A 2-entry skid FIFO absorbs in-flight read data while the stream is back-pressured, so the output runs at full throughput with no data loss.

Parameters:
ADDR_WIDTH, 12, memory address width; memory depth is 2**ADDR_WIDTH.
DATA_WIDTH, 32, data word width; must be a multiple of 8.
LEN_WIDTH, 13, burst length width; ADDR_WIDTH+1 so a full-memory burst (4096) is expressible.

Ports:
s01_axis_aclk  in  1  sole clock
s01_axis_aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a burst; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first word address, captured on an accepted start
burst_len  in  LEN_WIDTH  number of words, captured on an accepted start; 0 is legal
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the burst completes
mem_rd_en  out  1  read strobe to memory
mem_rd_addr  out  ADDR_WIDTH  read address to memory
mem_rd_data  in  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en
m01_axis_tdata  out  DATA_WIDTH  stream data
m01_axis_tstrb  out  DATA_WIDTH/8  byte strobes; all ones while tvalid
m01_axis_tvalid  out  1  stream valid
m01_axis_tlast  out  1  high on the final beat of the burst
m01_axis_tready  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0, state = IDLE, FIFO empty, counters 0.
  - Reset mid-burst abandons the burst; no done pulse is produced.
- States:
  - IDLE: start=1 and burst_len!=0 → READ; capture addr and len; set issue_cnt=0 and beat_cnt=0.
  - IDLE: start=1 and burst_len=0 → ZERO.
  - IDLE: start while already busy is ignored.
  - READ: issue reads. When issue_cnt reaches len → DRAIN.
  - DRAIN: wait until the final beat is accepted (tvalid & tready & tlast) → IDLE with done=1 for one cycle.
  - ZERO: one cycle with done=1 → IDLE. No reads are issued and no beats are produced.
- Read issue:
  - Issue mem_rd_en=1 in READ when (fifo_count + inflight) < 2, or when the sum equals 2 and a pop occurs this same cycle.
  - inflight is a 1-bit register equal to last cycle's mem_rd_en; the returning mem_rd_data is pushed into the FIFO when inflight=1.
  - mem_rd_addr = base_addr + issue_cnt, truncated to ADDR_WIDTH (wraps from 4095 to 0).
  - mem_rd_addr and mem_rd_en are driven combinationally from registered state.
- Stream output:
  - m01_axis_tvalid = FIFO not empty; tdata = FIFO head.
  - Pop occurs on tvalid & tready.
  - tlast = tvalid and (beat_cnt == len-1). beat_cnt increments on each pop.
  - Once tvalid rises, tdata, tlast and tvalid stay stable until accepted (AXI rule).
- Latency and throughput:
  - start → first mem_rd_en: 1 cycle.
  - First tvalid: 2 cycles after the first mem_rd_en is issued.
  - With tready held at 1, one beat per cycle.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Overflow is impossible by the issue rule; the implementation must include an assertion that it never occurs.
- done and tlast acceptance: done rises the cycle after the tlast handshake; busy falls in that same cycle.

Decomposition:
- Package mem_stream_pkg holds:
  - the state enum (IDLE, READ, DRAIN, ZERO);
  - default width constants (ADDR_WIDTH, DATA_WIDTH, LEN_WIDTH);
  - the SKID_DEPTH=2 constant.
- Sub-module stream_skid_fifo: 2-entry, 2-bit count, push/pop/full/empty, same clock and reset as the parent. The parent contains only the FSM, counters and issue logic.

Test Plan:
- Memory preloaded with mem[i]=i. start, base=10, len=4, tready=1 → beats 10, 11, 12, 13 on consecutive cycles; tlast on 13; done the cycle after; exactly 4 mem_rd_en pulses.
- base=4094, len=4 → addresses 4094, 4095, 0, 1; data matches and tlast lands on the 4th beat.
- len=8 with tready toggling 1,0,0,1 repeating → all 8 words in order with no drop or duplicate; tdata stable while tvalid=1 and tready=0; FIFO count never exceeds 2.
- len=0 → done pulses 1 cycle after start; mem_rd_en and tvalid stay 0.
- Reset asserted mid-burst (after 3 of 8 beats) → all outputs 0 immediately; no done. A fresh start (base=0, len=2) then completes normally.
- start pulsed again during a len=5 burst → ignored; exactly 5 beats and one done.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Shared types and default sizing for the memory read streamer and its skid FIFO.
package mem_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      ZERO  = 2'd3
   } state_e;

   localparam int DEFAULT_ADDR_WIDTH = 12;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_LEN_WIDTH  = DEFAULT_ADDR_WIDTH + 1;

   // At most one word is in flight from memory while one waits at the stream head.
   localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO that catches memory read data while the output stream is stalled.
module stream_skid_fifo
   import mem_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [1:0]            count,
   output logic                  full,
   output logic                  empty
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;
   logic                  do_push, do_pop;

   assign empty   = (count_q == 2'd0);
   assign full    = (count_q == 2'(SKID_DEPTH));
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // When full, a same-cycle push lands in the slot the head is leaving.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_rd_streamer.sv
// Burst read engine: issues memory reads and streams the returned words out as an AXI4-Stream burst.
module mem_rd_streamer
   import mem_stream_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
   input  logic                    s01_axis_aclk,
   input  logic                    s01_axis_aresetn,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [LEN_WIDTH-1:0]    burst_len,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
   output logic                    m01_axis_tvalid,
   output logic                    m01_axis_tlast,
   input  logic                    m01_axis_tready
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
   logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic                  inflight_q, inflight_d;
   logic                  done_q, done_d;

   logic [1:0]            fifo_count;
   logic                  fifo_full, fifo_empty;
   logic [1:0]            pending;
   logic                  pop, issue_ok, rd_en;

   // Words already buffered plus the one returning must fit in the skid FIFO.
   assign pending  = fifo_count + {1'b0, inflight_q};
   assign pop      = m01_axis_tvalid & m01_axis_tready;
   assign issue_ok = (pending < 2'(SKID_DEPTH)) | ((pending == 2'(SKID_DEPTH)) & pop);
   assign rd_en    = (state_q == READ) & (issue_cnt_q != len_q) & issue_ok;

   assign mem_rd_en       = rd_en;
   assign mem_rd_addr     = base_q + issue_cnt_q[ADDR_WIDTH-1:0];
   assign m01_axis_tvalid = ~fifo_empty;
   assign m01_axis_tstrb  = {(DATA_WIDTH/8){m01_axis_tvalid}};
   assign m01_axis_tlast  = m01_axis_tvalid & (beat_cnt_q == len_q - LEN_WIDTH'(1));
   assign busy            = (state_q == READ) | (state_q == DRAIN);
   assign done            = done_q;

   stream_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk   (s01_axis_aclk),
      .rst_n (s01_axis_aresetn),
      .push  (inflight_q),
      .pop   (pop),
      .din   (mem_rd_data),
      .dout  (m01_axis_tdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      inflight_d  = rd_en;
      done_d      = 1'b0;
      if (pop) begin
         beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               if (burst_len != '0) begin
                  state_d     = READ;
                  base_d      = base_addr;
                  len_d       = burst_len;
                  issue_cnt_d = '0;
                  beat_cnt_d  = '0;
               end else begin
                  state_d = ZERO;
                  done_d  = 1'b1;
               end
            end
         end
         READ: begin
            if (rd_en) begin
               issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
               if (issue_cnt_q + LEN_WIDTH'(1) == len_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && m01_axis_tlast) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         ZERO: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         inflight_q  <= inflight_d;
         done_q      <= done_d;
      end
   end

   // A returning word must always find room in the skid FIFO.
   a_no_overflow: assert property (@(posedge s01_axis_aclk) disable iff (!s01_axis_aresetn)
      !(inflight_q && fifo_full && !pop));

endmodule

// File: tb/tb_mem_rd_streamer.sv
// Self-checking bench for mem_rd_streamer: vector table, corner sequences and random bursts vs a burst model.
module tb_mem_rd_streamer;

   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int LW    = 13;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [AW-1:0] base;
      logic [LW-1:0] len;
      int            mode;
      int            exp_beats;
      int            exp_rd;
      int            exp_done_lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] burst_len = '0;
   logic          busy, done, mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic [DW-1:0] tdata;
   logic [DW/8-1:0] tstrb;
   logic          tvalid, tlast;
   logic          tready = 1'b0;

   logic [DW-1:0] mem [DEPTH];
   beat_t         exp_q[$];
   logic [AW-1:0] addr_q[$];
   vec_t          vecs[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_mode = 0;
   int phase = 0;
   int rd_cnt, beats, done_cnt, valid_cnt;
   int first_rd_cyc, first_valid_cyc, last_beat_cyc, done_cyc;
   int start_cyc = -10;
   logic busy_after;
   logic prev_valid = 1'b0;
   logic prev_ready, prev_last;
   logic [DW-1:0] prev_data;
   beat_t mon_e;

   always #5 clk = ~clk;

   mem_rd_streamer #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW)
   ) dut (
      .s01_axis_aclk    (clk),
      .s01_axis_aresetn (rst_n),
      .start            (start),
      .base_addr        (base_addr),
      .burst_len        (burst_len),
      .busy             (busy),
      .done             (done),
      .mem_rd_en        (mem_rd_en),
      .mem_rd_addr      (mem_rd_addr),
      .mem_rd_data      (mem_rd_data),
      .m01_axis_tdata   (tdata),
      .m01_axis_tstrb   (tstrb),
      .m01_axis_tvalid  (tvalid),
      .m01_axis_tlast   (tlast),
      .m01_axis_tready  (tready)
   );

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       tready = 1'b1;
         1:       tready = ((phase % 4) == 0) || ((phase % 4) == 3);
         default: tready = 1'($urandom_range(0, 1));
      endcase
      phase++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic reportFail(input string name, input int act, input int exp);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Mid-cycle monitor: scoreboard beats and read addresses, check AXI hold rules.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         check("tstrb", 64'(tstrb), tvalid ? 64'((1 << (DW/8)) - 1) : 64'd0);
         if (!tvalid) check("tlast_idle", 64'(tlast), 64'd0);
         if (prev_valid && !prev_ready) begin
            check("hold_valid", 64'(tvalid), 64'd1);
            check("hold_data", 64'(tdata), 64'(prev_data));
            check("hold_last", 64'(tlast), 64'(prev_last));
         end
         if (mem_rd_en) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (addr_q.size() == 0) reportFail("rd_extra", rd_cnt, 0);
            else check("rd_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
         end
         if (tvalid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (tvalid && tready) begin
            beats++;
            last_beat_cyc = cyc;
            if (exp_q.size() == 0) begin
               reportFail("beat_extra", beats, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("tdata", 64'(tdata), 64'(mon_e.data));
               check("tlast", 64'(tlast), 64'(mon_e.last));
            end
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            check("busy_at_done", 64'(busy), 64'd0);
         end
         if (cyc == start_cyc + 1) busy_after = busy;
         prev_valid = tvalid;
         prev_ready = tready;
         prev_data  = tdata;
         prev_last  = tlast;
      end
   end

   task automatic checkReset(input string tag);
      check({tag, "_busy"},   64'(busy),        64'd0);
      check({tag, "_done"},   64'(done),        64'd0);
      check({tag, "_rd_en"},  64'(mem_rd_en),   64'd0);
      check({tag, "_rd_addr"},64'(mem_rd_addr), 64'd0);
      check({tag, "_tdata"},  64'(tdata),       64'd0);
      check({tag, "_tstrb"},  64'(tstrb),       64'd0);
      check({tag, "_tvalid"}, 64'(tvalid),      64'd0);
      check({tag, "_tlast"},  64'(tlast),       64'd0);
   endtask

   // Builds the expected burst from the address/length rules, then pulses start.
   task automatic applyStimulus(input logic [AW-1:0] b, input logic [LW-1:0] l);
      logic [AW-1:0] a;
      beat_t         e;
      exp_q.delete();
      addr_q.delete();
      for (int k = 0; k < int'(l); k++) begin
         a      = AW'((int'(b) + k) % DEPTH);
         e.data = mem[a];
         e.last = (k == int'(l) - 1);
         addr_q.push_back(a);
         exp_q.push_back(e);
      end
      rd_cnt = 0; beats = 0; done_cnt = 0; valid_cnt = 0;
      first_rd_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
      busy_after = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; burst_len = l;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = AW'($urandom);
      burst_len = LW'($urandom);
   endtask

   task automatic waitDone(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt == 0) reportFail("done_timeout", n, budget);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input vec_t v);
      check("beats", 64'(beats), 64'(v.exp_beats));
      check("rd_pulses", 64'(rd_cnt), 64'(v.exp_rd));
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("model_left", 64'(exp_q.size()), 64'd0);
      if (v.exp_done_lat >= 0) check("done_latency", 64'(done_cyc - start_cyc), 64'(v.exp_done_lat));
      if (v.len != 0) begin
         check("first_rd_lat", 64'(first_rd_cyc - start_cyc), 64'd1);
         check("first_valid_lat", 64'(first_valid_cyc - first_rd_cyc), 64'd2);
         check("done_after_tlast", 64'(done_cyc - last_beat_cyc), 64'd1);
         check("busy_after_start", 64'(busy_after), 64'd1);
      end else begin
         check("zero_valid_cycles", 64'(valid_cnt), 64'd0);
      end
   endtask

   initial begin
      vec_t v;
      int   n;
      logic [AW-1:0] rb;
      logic [LW-1:0] rl;
      int   rm;

      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

      vecs.push_back('{12'd10,   13'd4,    0, 4,    4,    7});
      vecs.push_back('{12'd4094, 13'd4,    0, 4,    4,    7});
      vecs.push_back('{12'd100,  13'd8,    1, 8,    8,    -1});
      vecs.push_back('{12'd37,   13'd0,    0, 0,    0,    1});
      vecs.push_back('{12'd4095, 13'd1,    0, 1,    1,    4});
      vecs.push_back('{12'd50,   13'd16,   2, 16,   16,   -1});
      vecs.push_back('{12'd7,    13'd4096, 0, 4096, 4096, 4099});

      #1 rst_n = 1'b0;
      #2 checkReset("por");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[i]) begin
         ready_mode = vecs[i].mode;
         applyStimulus(vecs[i].base, vecs[i].len);
         waitDone(50 + 10 * int'(vecs[i].len));
         checkOutput(vecs[i]);
      end

      // A second start while busy must be ignored.
      ready_mode = 0;
      applyStimulus(12'd300, 13'd5);
      repeat (2) @(posedge clk);
      #1 start = 1'b1; base_addr = 12'd999; burst_len = 13'd3;
      @(posedge clk);
      #1 start = 1'b0;
      waitDone(100);
      repeat (10) @(posedge clk);
      #1;
      check("restart_beats", 64'(beats), 64'd5);
      check("restart_rd", 64'(rd_cnt), 64'd5);
      check("restart_done", 64'(done_cnt), 64'd1);
      check("restart_model_left", 64'(exp_q.size()), 64'd0);

      // Reset after three accepted beats abandons the burst silently.
      ready_mode = 0;
      applyStimulus(12'd200, 13'd8);
      n = 0;
      while (beats < 3 && n < 50) begin
         @(posedge clk);
         n++;
      end
      if (beats < 3) reportFail("mid_reset_wait", beats, 3);
      #1 rst_n = 1'b0;
      #1 checkReset("mid_reset");
      exp_q.delete();
      addr_q.delete();
      repeat (4) @(posedge clk);
      check("no_done_after_reset", 64'(done_cnt), 64'd0);
      #1 rst_n = 1'b1;
      applyStimulus(12'd0, 13'd2);
      waitDone(50);
      v = '{12'd0, 13'd2, 0, 2, 2, 5};
      checkOutput(v);

      for (int r = 0; r < 25; r++) begin
         rb = AW'($urandom_range(0, DEPTH - 1));
         rl = LW'($urandom_range(0, 20));
         rm = $urandom_range(0, 2);
         ready_mode = rm;
         v = '{rb, rl, rm, int'(rl), int'(rl),
               (rl == 0) ? 1 : ((rm == 0) ? int'(rl) + 3 : -1)};
         applyStimulus(rb, rl);
         waitDone(50 + 10 * int'(rl));
         checkOutput(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
